pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/cpu_types_pkg.sv | 53 +++++
 rtl/hazard_detect.sv | 25 ++
 rtl/pipe_hazard_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg
//   Shared CPU types plus the hazard-controller definitions: pipeline
//   hazard FSM state, default watchdog limit and the bundle of pipeline
//   control lines driven by the hazard controller.
//   No ports (package).
package cpu_types_pkg;

    typedef logic [4:0]  regbits_t;
    typedef logic [31:0] word_t;

    // Encoding 2'd3 is never entered on purpose; the FSM treats it as RUN-recovery.
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        HALT    = 2'd2
    } hzstate_t;

    localparam int WDOG_CYCLES_DEFAULT = 1023;
    localparam int WAIT_CNT_W          = 16;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idex_flush;
        logic idex_stall;
    } hz_ctl_t;

    // Whole pipeline frozen: nothing advances, ID/EX holds its contents.
    localparam hz_ctl_t CTL_FREEZE = '{pc_en: 1'b0, ifid_en: 1'b0, exmem_en: 1'b0,
                                       memwb_en: 1'b0, ifid_flush: 1'b0,
                                       idex_flush: 1'b0, idex_stall: 1'b1};
    // Normal flow: every latch loads.
    localparam hz_ctl_t CTL_GO     = '{pc_en: 1'b1, ifid_en: 1'b1, exmem_en: 1'b1,
                                       memwb_en: 1'b1, ifid_flush: 1'b0,
                                       idex_flush: 1'b0, idex_stall: 1'b0};
    // Control transfer resolved in EX: both younger instructions are wrong-path.
    localparam hz_ctl_t CTL_REDIR  = '{pc_en: 1'b1, ifid_en: 1'b1, exmem_en: 1'b1,
                                       memwb_en: 1'b1, ifid_flush: 1'b1,
                                       idex_flush: 1'b1, idex_stall: 1'b0};
    // Load-use: hold PC and IF/ID, insert one bubble into EX.
    localparam hz_ctl_t CTL_LDUSE  = '{pc_en: 1'b0, ifid_en: 1'b0, exmem_en: 1'b1,
                                       memwb_en: 1'b1, ifid_flush: 1'b0,
                                       idex_flush: 1'b1, idex_stall: 1'b0};
    // I-cache miss: hold PC, feed a bubble into ID while older work drains.
    localparam hz_ctl_t CTL_IMISS  = '{pc_en: 1'b0, ifid_en: 1'b1, exmem_en: 1'b1,
                                       memwb_en: 1'b1, ifid_flush: 1'b1,
                                       idex_flush: 1'b0, idex_stall: 1'b0};
    localparam hz_ctl_t CTL_IDLE   = '0;

endpackage

// File: rtl/hazard_detect.sv
// hazard_detect
//   Combinational load-use detector: a load in EX whose destination is a
//   source of the instruction in ID.  Register 0 never creates a hazard.
//   Ports:
//     idex_dren     in   load in EX
//     idex_rt       in   load destination register
//     ifid_rs       in   ID source rs
//     ifid_rt       in   ID source rt
//     ifid_uses_rt  in   ID instruction actually reads rt
//     load_use      out  hazard present
module hazard_detect
    import cpu_types_pkg::*;
(
    input  logic     idex_dren,
    input  regbits_t idex_rt,
    input  regbits_t ifid_rs,
    input  regbits_t ifid_rt,
    input  logic     ifid_uses_rt,
    output logic     load_use
);

    assign load_use = idex_dren && (idex_rt != '0) &&
                      ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Hazard/stall controller for a 5-stage pipeline.  A small FSM
//   (RUN / MEMWAIT / HALT) plus combinational priority logic produce the
//   stage enables, bubble (flush) controls and ID/EX hold.  A watchdog
//   counts MEMWAIT cycles and raises a sticky mem_timeout.
//   Optional feature macro: PIPE_PERF_CNT_EN adds stall_cycles and
//   flush_count performance counters.
//   Ports:
//     CLK, RST                  clock (rising), synchronous active-high reset
//     ihit, dhit                fetch hit / data access complete
//     exmem_dREN, exmem_dWEN    memory op in MEM
//     idex_dREN, idex_rt        load in EX and its destination
//     ifid_rs, ifid_rt          ID sources; ifid_uses_rt = ID reads rt
//     pc_redirect               taken branch / jump resolved in EX
//     halt_in                   halt instruction in MEM
//     pc_en, ifid_en, exmem_en, memwb_en   stage enables
//     ifid_flush, idex_flush    load a bubble
//     idex_stall                hold ID/EX
//     halt_out, mem_timeout     sticky status
//     state_o                   current FSM state
//     stall_cycles, flush_count (PIPE_PERF_CNT_EN only)
module pipe_hazard_ctrl
    import cpu_types_pkg::*;
#(
    parameter int WDOG_CYCLES = WDOG_CYCLES_DEFAULT
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       ihit,
    input  logic       dhit,
    input  logic       exmem_dREN,
    input  logic       exmem_dWEN,
    input  logic       idex_dREN,
    input  regbits_t   idex_rt,
    input  regbits_t   ifid_rs,
    input  regbits_t   ifid_rt,
    input  logic       ifid_uses_rt,
    input  logic       pc_redirect,
    input  logic       halt_in,
    output logic       pc_en,
    output logic       ifid_en,
    output logic       exmem_en,
    output logic       memwb_en,
    output logic       ifid_flush,
    output logic       idex_flush,
    output logic       idex_stall,
    output logic       halt_out,
    output logic       mem_timeout,
    output logic [1:0] state_o
`ifdef PIPE_PERF_CNT_EN
    ,
    output word_t      stall_cycles,
    output word_t      flush_count
`endif
);

    localparam logic [31:0] WDOG_LIMIT = 32'(WDOG_CYCLES);
    localparam logic        WDOG_ON    = (WDOG_CYCLES != 0);

    hzstate_t              state_q, state_d;
    logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d, wait_inc;
    logic                  mem_timeout_q, mem_timeout_d;
    hz_ctl_t               ctl;
    logic                  load_use;
    logic                  memwait;

    hazard_detect u_hazard_detect (
        .idex_dren    (idex_dREN),
        .idex_rt      (idex_rt),
        .ifid_rs      (ifid_rs),
        .ifid_rt      (ifid_rt),
        .ifid_uses_rt (ifid_uses_rt),
        .load_use     (load_use)
    );

    assign memwait = (exmem_dREN || exmem_dWEN) && !dhit;

    // Next state and control outputs.  Only the highest-priority event acts.
    always_comb begin
        state_d = state_q;
        ctl     = CTL_FREEZE;
        case (state_q)
            RUN: begin
                if (halt_in) begin
                    state_d = HALT;
                end else if (memwait) begin
                    state_d = MEMWAIT;
                end else if (pc_redirect) begin
                    ctl = CTL_REDIR;
                end else if (load_use) begin
                    ctl = CTL_LDUSE;
                end else if (!ihit) begin
                    ctl = CTL_IMISS;
                end else begin
                    ctl = CTL_GO;
                end
            end
            MEMWAIT: begin
                // A redirect seen here is left alone: EX is frozen so the
                // branch stays put and is acted on in the following RUN cycle.
                if (dhit) begin
                    state_d = RUN;
                    ctl     = CTL_GO;
                end
            end
            HALT: begin
                ctl = CTL_FREEZE;
            end
            default: begin
                state_d = RUN;
            end
        endcase
        if (RST) begin
            ctl = CTL_IDLE;
        end
    end

    // Watchdog: the exit cycle of MEMWAIT still counts as a waiting cycle.
    always_comb begin
        wait_inc      = (wait_cnt_q == {WAIT_CNT_W{1'b1}}) ? wait_cnt_q : wait_cnt_q + 1'b1;
        wait_cnt_d    = '0;
        mem_timeout_d = mem_timeout_q;
        if (state_q == MEMWAIT) begin
            if (state_d == MEMWAIT) begin
                wait_cnt_d = wait_inc;
            end
            if (WDOG_ON && (32'(wait_inc) == WDOG_LIMIT)) begin
                mem_timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= RUN;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    assign pc_en       = ctl.pc_en;
    assign ifid_en     = ctl.ifid_en;
    assign exmem_en    = ctl.exmem_en;
    assign memwb_en    = ctl.memwb_en;
    assign ifid_flush  = ctl.ifid_flush;
    assign idex_flush  = ctl.idex_flush;
    assign idex_stall  = ctl.idex_stall;
    assign halt_out    = (state_q == HALT);
    assign mem_timeout = mem_timeout_q;
    assign state_o     = state_q;

`ifdef PIPE_PERF_CNT_EN
    word_t stall_cycles_q, stall_cycles_d;
    word_t flush_count_q, flush_count_d;

    // Reset cycles already have pc_en=0 forced low but are excluded via the
    // flop reset; HALT cycles are excluded explicitly.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if (!ctl.pc_en && (state_q != HALT)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
        if (ctl.idex_flush) begin
            flush_count_d = flush_count_q + 32'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl
//   Self-checking bench for pipe_hazard_ctrl (default build, watchdog = 8).
//   Directed scenarios with literal expectations, then randomized traffic,
//   all checked every cycle against a behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int WDOG = 8;

    logic       CLK = 1'b0;
    logic       RST;
    logic       ihit, dhit, exmem_dREN, exmem_dWEN, idex_dREN;
    logic [4:0] idex_rt, ifid_rs, ifid_rt;
    logic       ifid_uses_rt, pc_redirect, halt_in;
    logic       pc_en, ifid_en, exmem_en, memwb_en;
    logic       ifid_flush, idex_flush, idex_stall;
    logic       halt_out, mem_timeout;
    logic [1:0] state_o;

    always #5 CLK = ~CLK;

    pipe_hazard_ctrl #(.WDOG_CYCLES(WDOG)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .ihit         (ihit),
        .dhit         (dhit),
        .exmem_dREN   (exmem_dREN),
        .exmem_dWEN   (exmem_dWEN),
        .idex_dREN    (idex_dREN),
        .idex_rt      (idex_rt),
        .ifid_rs      (ifid_rs),
        .ifid_rt      (ifid_rt),
        .ifid_uses_rt (ifid_uses_rt),
        .pc_redirect  (pc_redirect),
        .halt_in      (halt_in),
        .pc_en        (pc_en),
        .ifid_en      (ifid_en),
        .exmem_en     (exmem_en),
        .memwb_en     (memwb_en),
        .ifid_flush   (ifid_flush),
        .idex_flush   (idex_flush),
        .idex_stall   (idex_stall),
        .halt_out     (halt_out),
        .mem_timeout  (mem_timeout),
        .state_o      (state_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: mode 0 = running, 1 = waiting on memory, 2 = halted.
    int m_mode = 0;
    int m_wait = 0;
    bit m_to   = 1'b0;

    // Expected {pc_en, ifid_en, exmem_en, memwb_en, ifid_flush, idex_flush, idex_stall}
    function automatic logic [6:0] model_ctl();
        bit mw, lu;
        mw = (exmem_dREN || exmem_dWEN) && !dhit;
        lu = idex_dREN && (idex_rt != 0) &&
             ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));
        if (RST) return 7'b0000_00_0;
        if (m_mode == 2) return 7'b0000_00_1;
        if (m_mode == 1) return dhit ? 7'b1111_00_0 : 7'b0000_00_1;
        if (halt_in || mw) return 7'b0000_00_1;
        if (pc_redirect)   return 7'b1111_11_0;
        if (lu)            return 7'b0011_01_0;
        if (!ihit)         return 7'b0111_10_0;
        return 7'b1111_00_0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Mid-cycle: compare every output with the model.
    task automatic half();
        logic [6:0] e;
        #4;
        e = model_ctl();
        check("m_pc_en",      32'(pc_en),      32'(e[6]));
        check("m_ifid_en",    32'(ifid_en),    32'(e[5]));
        check("m_exmem_en",   32'(exmem_en),   32'(e[4]));
        check("m_memwb_en",   32'(memwb_en),   32'(e[3]));
        check("m_ifid_flush", 32'(ifid_flush), 32'(e[2]));
        check("m_idex_flush", 32'(idex_flush), 32'(e[1]));
        check("m_idex_stall", 32'(idex_stall), 32'(e[0]));
        check("m_state_o",    32'(state_o),    32'(m_mode));
        check("m_halt_out",   32'(halt_out),   32'(m_mode == 2));
        check("m_mem_timeout",32'(mem_timeout),32'(m_to));
    endtask

    // Clock edge: advance the model with the inputs that were just sampled.
    task automatic edge_();
        @(posedge CLK);
        if (RST) begin
            m_mode = 0;
            m_wait = 0;
            m_to   = 1'b0;
        end else if (m_mode == 0) begin
            if (halt_in) begin
                m_mode = 2;
            end else if ((exmem_dREN || exmem_dWEN) && !dhit) begin
                m_mode = 1;
                m_wait = 0;
            end
        end else if (m_mode == 1) begin
            if (m_wait < 65535) m_wait++;
            if (WDOG != 0 && m_wait == WDOG) m_to = 1'b1;
            if (dhit) begin
                m_mode = 0;
                m_wait = 0;
            end
        end
        #1;
    endtask

    task automatic idle();
        RST = 1'b0; ihit = 1'b1; dhit = 1'b1;
        exmem_dREN = 1'b0; exmem_dWEN = 1'b0; idex_dREN = 1'b0;
        idex_rt = '0; ifid_rs = '0; ifid_rt = '0;
        ifid_uses_rt = 1'b0; pc_redirect = 1'b0; halt_in = 1'b0;
    endtask

    initial begin
        int dhit_pct;
        idle();
        RST = 1'b1;
        edge_();

        // Reset state
        half();
        check("rst_pc_en",   32'(pc_en), 0);
        check("rst_stall",   32'(idex_stall), 0);
        check("rst_state",   32'(state_o), 0);
        check("rst_halt",    32'(halt_out), 0);
        check("rst_timeout", 32'(mem_timeout), 0);
        edge_();
        RST = 1'b0;
        half();
        check("run_enables", 32'({pc_en, ifid_en, exmem_en, memwb_en}), 32'hF);
        edge_();

        // Load-use on rs: exactly one bubble
        idex_dREN = 1'b1; idex_rt = 5'd5; ifid_rs = 5'd5;
        half();
        check("lu_pc_en",      32'(pc_en), 0);
        check("lu_ifid_en",    32'(ifid_en), 0);
        check("lu_idex_flush", 32'(idex_flush), 1);
        check("lu_exmem_en",   32'(exmem_en), 1);
        edge_();
        idex_dREN = 1'b0;
        half();
        check("lu_next_pc_en",   32'(pc_en), 1);
        check("lu_next_ifid_en", 32'(ifid_en), 1);
        check("lu_next_flush",   32'(idex_flush), 0);
        edge_();

        // Load-use on rt only when rt is read
        idex_dREN = 1'b1; idex_rt = 5'd7; ifid_rs = 5'd3; ifid_rt = 5'd7; ifid_uses_rt = 1'b1;
        half();
        check("lu_rt_pc_en", 32'(pc_en), 0);
        edge_();
        ifid_uses_rt = 1'b0;
        half();
        check("lu_rt_unread_pc_en", 32'(pc_en), 1);
        edge_();

        // Register 0 never stalls
        idex_rt = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0; ifid_uses_rt = 1'b1;
        half();
        check("zero_pc_en", 32'(pc_en), 1);
        check("zero_flush", 32'(idex_flush), 0);
        edge_();
        idle();

        // Instruction miss
        ihit = 1'b0;
        half();
        check("imiss_pc_en",      32'(pc_en), 0);
        check("imiss_ifid_flush", 32'(ifid_flush), 1);
        check("imiss_ifid_en",    32'(ifid_en), 1);
        check("imiss_exmem_en",   32'(exmem_en), 1);
        edge_();
        ihit = 1'b1;

        // Memwait: 4 cycles of dhit=0, then dhit=1
        exmem_dREN = 1'b1; dhit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            half();
            check("mw_enables", 32'({pc_en, ifid_en, exmem_en, memwb_en}), 0);
            check("mw_stall",   32'(idex_stall), 1);
            check("mw_flush",   32'({ifid_flush, idex_flush}), 0);
            if (i > 0) check("mw_state", 32'(state_o), 1);
            edge_();
        end
        dhit = 1'b1;
        half();
        check("mw_exit_state",   32'(state_o), 1);
        check("mw_exit_enables", 32'({pc_en, ifid_en, exmem_en, memwb_en}), 32'hF);
        check("mw_exit_stall",   32'(idex_stall), 0);
        edge_();
        exmem_dREN = 1'b0;
        half();
        check("mw_after_state", 32'(state_o), 0);
        check("mw_no_timeout",  32'(mem_timeout), 0);
        edge_();

        // Redirect beats load-use and imiss
        idex_dREN = 1'b1; idex_rt = 5'd5; ifid_rs = 5'd5; pc_redirect = 1'b1; ihit = 1'b0;
        half();
        check("prio_pc_en",      32'(pc_en), 1);
        check("prio_ifid_flush", 32'(ifid_flush), 1);
        check("prio_idex_flush", 32'(idex_flush), 1);
        edge_();
        idle();

        // Redirect held through MEMWAIT acts in the RUN cycle after exit
        exmem_dWEN = 1'b1; dhit = 1'b0; pc_redirect = 1'b1;
        half();
        check("mwr_entry_flush", 32'(ifid_flush), 0);
        check("mwr_entry_pc_en", 32'(pc_en), 0);
        edge_();
        half();
        check("mwr_wait_state", 32'(state_o), 1);
        check("mwr_wait_flush", 32'(ifid_flush), 0);
        edge_();
        dhit = 1'b1;
        half();
        check("mwr_exit_flush", 32'({ifid_flush, idex_flush}), 0);
        edge_();
        exmem_dWEN = 1'b0;
        half();
        check("mwr_run_flush", 32'({ifid_flush, idex_flush}), 32'h3);
        edge_();
        idle();

        // Watchdog: timeout right after the 8th MEMWAIT cycle, then sticky
        exmem_dREN = 1'b1; dhit = 1'b0;
        half();
        edge_();
        for (int k = 1; k <= WDOG; k++) begin
            half();
            check("wd_not_yet", 32'(mem_timeout), 0);
            edge_();
        end
        half();
        check("wd_set",   32'(mem_timeout), 1);
        check("wd_state", 32'(state_o), 1);
        edge_();
        dhit = 1'b1;
        half();
        edge_();
        exmem_dREN = 1'b0;
        half();
        check("wd_sticky",    32'(mem_timeout), 1);
        check("wd_run_state", 32'(state_o), 0);
        edge_();
        RST = 1'b1;
        half();
        edge_();
        RST = 1'b0;
        half();
        check("wd_cleared", 32'(mem_timeout), 0);
        edge_();

        // Halt is absorbing until reset
        halt_in = 1'b1;
        half();
        check("halt_in_pc_en", 32'(pc_en), 0);
        check("halt_in_stall", 32'(idex_stall), 1);
        edge_();
        halt_in = 1'b0; ihit = 1'b0; pc_redirect = 1'b1;
        for (int i = 0; i < 3; i++) begin
            half();
            check("halt_state",    32'(state_o), 2);
            check("halt_out",      32'(halt_out), 1);
            check("halt_enables",  32'({pc_en, ifid_en, exmem_en, memwb_en}), 0);
            edge_();
        end
        idle();
        RST = 1'b1;
        half();
        edge_();
        RST = 1'b0;
        half();
        check("halt_rst_state", 32'(state_o), 0);
        check("halt_rst_out",   32'(halt_out), 0);
        edge_();

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            dhit_pct     = ((c / 500) % 2 == 1) ? 12 : 60;
            RST          = ($urandom_range(0, 99) < ((m_mode == 2) ? 15 : 2));
            ihit         = ($urandom_range(0, 99) < 85);
            dhit         = ($urandom_range(0, 99) < dhit_pct);
            exmem_dREN   = ($urandom_range(0, 99) < 20);
            exmem_dWEN   = ($urandom_range(0, 99) < 10);
            idex_dREN    = ($urandom_range(0, 99) < 40);
            idex_rt      = 5'($urandom_range(0, 3));
            ifid_rs      = 5'($urandom_range(0, 3));
            ifid_rt      = 5'($urandom_range(0, 3));
            ifid_uses_rt = ($urandom_range(0, 1) == 1);
            pc_redirect  = ($urandom_range(0, 99) < 15);
            halt_in      = ($urandom_range(0, 199) == 0);
            half();
            edge_();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
